// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write port arbiter with long-latency scoreboard
//
// Purpose:
//   Shares the register file's single write port between two writeback sources.
//   The in-order pipeline (source A) has priority. Long-latency results (source B)
//   wait in a small FIFO. A starvation counter guarantees forward progress for
//   the FIFO head. A per-register busy scoreboard tracks outstanding long-latency
//   destinations so the issue stage can stall on RAW hazards.
//
// Configuration:
//   RF_WB_BYPASS_EN - when defined, byp*_hit/byp*_data expose the current rf write
//                     for a same-cycle write-then-read; otherwise they are tied to 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data pipeline writeback request (priority source)
//   b_valid/b_ready/b_rd/b_data long-latency result into the FIFO
//   iss_set/iss_rd              long-latency op issued, marks iss_rd busy
//   rs1/rs2, rs1_busy/rs2_busy  issue-stage source lookup into the scoreboard
//   rf_we/rf_rd/rf_data         registered write port to the register file
//   byp1_hit/byp1_data          bypass of the current rf write to rs1
//   byp2_hit/byp2_data          bypass of the current rf write to rs2

module rf_wb_arbiter #(
   parameter int QDEPTH       = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_rd,
   input  logic [63:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [63:0] b_data,
   input  logic        iss_set,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [63:0] rf_data,
   output logic        byp1_hit,
   output logic        byp2_hit,
   output logic [63:0] byp1_data,
   output logic [63:0] byp2_data
);

   localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW  = PW + 1;
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   // Source-B FIFO storage
   logic [4:0]     mem_rd   [QDEPTH];
   logic [63:0]    mem_data [QDEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   logic [SCW-1:0] starve_cnt;
   logic [31:0]    busy;
   logic [31:0]    busy_nxt;

   logic           fifo_empty;
   logic           fifo_full;
   logic           push;
   logic           starved;
   logic           grant_a;
   logic           grant_b;
   logic [4:0]     head_rd;
   logic [63:0]    head_data;
   logic [4:0]     win_rd;
   logic [63:0]    win_data;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(QDEPTH));
   assign head_rd    = mem_rd[rd_ptr];
   assign head_data  = mem_data[rd_ptr];

   // b_ready looks only at the current count, so a pop this cycle does not
   // open a slot until the next one.
   assign b_ready = ~fifo_full;
   assign push    = b_valid & b_ready;

   // Once the head has been passed over STARVE_LIMIT times, A is held off for
   // one cycle so the head is guaranteed the port.
   assign starved = ~fifo_empty & (starve_cnt == SCW'(STARVE_LIMIT));
   assign a_ready = ~starved;

   assign grant_a = a_valid & a_ready;
   assign grant_b = ~grant_a & ~fifo_empty;

   always_comb begin
      win_rd   = '0;
      win_data = '0;
      if (grant_a) begin
         win_rd   = a_rd;
         win_data = a_data;
      end else if (grant_b) begin
         win_rd   = head_rd;
         win_data = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr]   <= b_rd;
         mem_data[wr_ptr] <= b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (grant_b) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, grant_b})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (fifo_empty || grant_b) begin
         starve_cnt <= '0;
      end else if (starve_cnt != SCW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + SCW'(1);
      end
   end

   // Writes to x0 still consume the grant but never assert the write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we   <= 1'b0;
         rf_rd   <= '0;
         rf_data <= '0;
      end else begin
         rf_we   <= (grant_a | grant_b) & (win_rd != 5'd0);
         rf_rd   <= win_rd;
         rf_data <= win_data;
      end
   end

   // Scoreboard: clear on head grant first, then a same-cycle issue of the
   // same register re-sets it, so set wins.
   always_comb begin
      busy_nxt = busy;
      if (grant_b) begin
         busy_nxt[head_rd] = 1'b0;
      end
      if (iss_set && (iss_rd != 5'd0)) begin
         busy_nxt[iss_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign rs1_busy = busy[rs1];
   assign rs2_busy = busy[rs2];

`ifdef RF_WB_BYPASS_EN
   assign byp1_hit  = rf_we & (rf_rd == rs1) & (rs1 != 5'd0);
   assign byp2_hit  = rf_we & (rf_rd == rs2) & (rs2 != 5'd0);
   assign byp1_data = rf_data;
   assign byp2_data = rf_data;
`else
   assign byp1_hit  = 1'b0;
   assign byp2_hit  = 1'b0;
   assign byp1_data = '0;
   assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter

module tb_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_rd;
   logic [63:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [63:0] b_data;
   logic        iss_set;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [63:0] rf_data;
   logic        byp1_hit;
   logic        byp2_hit;
   logic [63:0] byp1_data;
   logic [63:0] byp2_data;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef RF_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   rf_wb_arbiter #(.QDEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_rd      (b_rd),
      .b_data    (b_data),
      .iss_set   (iss_set),
      .iss_rd    (iss_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_data   (rf_data),
      .byp1_hit  (byp1_hit),
      .byp2_hit  (byp2_hit),
      .byp1_data (byp1_data),
      .byp2_data (byp2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      iss_set = 1'b0; iss_rd = '0; rs1 = 5'd7; rs2 = 5'd9;
      tick(); tick();
      rst = 1'b0;
      settle();

      // reset / idle
      chk("rst_rf_we",    rf_we,    1'b0);
      chk("rst_rf_rd",    rf_rd,    5'd0);
      chk("rst_rf_data",  rf_data,  64'd0);
      chk("rst_b_ready",  b_ready,  1'b1);
      chk("rst_a_ready",  a_ready,  1'b1);
      chk("rst_rs1_busy", rs1_busy, 1'b0);
      chk("rst_rs2_busy", rs2_busy, 1'b0);
      tick();
      chk("idle_rf_we",   rf_we,    1'b0);

      // source A write, then x0 write
      a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
      tick();
      chk("a_rf_we",   rf_we,   1'b1);
      chk("a_rf_rd",   rf_rd,   5'd5);
      chk("a_rf_data", rf_data, 64'h1234);
      a_rd = 5'd0; a_data = 64'h99;
      tick();
      chk("a_x0_rf_we", rf_we, 1'b0);
      a_valid = 1'b0;
      tick();
      chk("a_idle_rf_we", rf_we, 1'b0);

      // scoreboard set by issue, cleared by B grant
      iss_set = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
      tick();
      iss_set = 1'b0;
      settle();
      chk("sb_set_rs1_busy", rs1_busy, 1'b1);
      b_valid = 1'b1; b_rd = 5'd7; b_data = 64'hAA;
      settle();
      chk("sb_b_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      settle();
      chk("sb_pre_grant_busy", rs1_busy, 1'b1);
      chk("sb_pre_grant_we",   rf_we,    1'b0);
      tick();
      chk("sb_b_rf_we",   rf_we,    1'b1);
      chk("sb_b_rf_rd",   rf_rd,    5'd7);
      chk("sb_b_rf_data", rf_data,  64'hAA);
      chk("sb_cleared",   rs1_busy, 1'b0);
      tick();
      chk("sb_after_we",  rf_we,    1'b0);

      // starvation: A held continuously, two B entries queued
      a_valid = 1'b1; a_rd = 5'd10; a_data = 64'h100;
      b_valid = 1'b1; b_rd = 5'd11; b_data = 64'hB1;
      tick();                                   // E1: push 11, A written
      b_rd = 5'd12; b_data = 64'hB2;
      settle();
      chk("st_b_ready_1", b_ready, 1'b1);
      tick();                                   // E2: push 12, count=1
      b_valid = 1'b0;
      settle();
      chk("st_full_b_ready", b_ready, 1'b0);
      chk("st_a_ready_c1",   a_ready, 1'b1);
      chk("st_rf_rd_a",      rf_rd,   5'd10);
      tick();                                   // count=2
      chk("st_a_ready_c2", a_ready, 1'b1);
      tick();                                   // count=3
      chk("st_a_ready_c3", a_ready, 1'b1);
      tick();                                   // count=4
      chk("st_a_ready_lim", a_ready, 1'b0);
      chk("st_lim_rf_rd",   rf_rd,   5'd10);
      tick();                                   // head granted
      chk("st_h1_rf_we",   rf_we,   1'b1);
      chk("st_h1_rf_rd",   rf_rd,   5'd11);
      chk("st_h1_rf_data", rf_data, 64'hB1);
      chk("st_h1_a_ready", a_ready, 1'b1);
      chk("st_h1_b_ready", b_ready, 1'b1);
      tick(); tick(); tick();
      chk("st_r3_a_ready", a_ready, 1'b1);
      chk("st_r3_rf_rd",   rf_rd,   5'd10);
      tick();
      chk("st_r4_a_ready", a_ready, 1'b0);
      tick();
      chk("st_h2_rf_rd",   rf_rd,   5'd12);
      chk("st_h2_rf_data", rf_data, 64'hB2);
      chk("st_h2_a_ready", a_ready, 1'b1);
      a_valid = 1'b0;
      tick();

      // same-cycle set and clear of r9: set wins
      rs2 = 5'd9;
      iss_set = 1'b1; iss_rd = 5'd9;
      tick();
      iss_set = 1'b0;
      b_valid = 1'b1; b_rd = 5'd9; b_data = 64'h9;
      tick();
      b_valid = 1'b0;
      iss_set = 1'b1; iss_rd = 5'd9;
      tick();
      iss_set = 1'b0;
      settle();
      chk("sw_rf_rd",     rf_rd,    5'd9);
      chk("sw_rs2_busy",  rs2_busy, 1'b1);
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      chk("sw_clear_busy", rs2_busy, 1'b0);

      // x0 never busy
      iss_set = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
      tick();
      iss_set = 1'b0;
      settle();
      chk("x0_busy", rs1_busy, 1'b0);

      // bypass
      a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h55; rs1 = 5'd3; rs2 = 5'd3;
      tick();
      a_valid = 1'b0;
      settle();
      chk("byp1_hit",  byp1_hit,  BYP);
      chk("byp1_data", byp1_data, BYP ? 64'h55 : 64'h0);
      chk("byp2_hit",  byp2_hit,  BYP);
      rs1 = 5'd0;
      settle();
      chk("byp1_x0_hit", byp1_hit, 1'b0);
      tick();

      // reset mid-operation discards queued entry and busy bits
      iss_set = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
      a_valid = 1'b1; a_rd = 5'd4; a_data = 64'h44;
      b_valid = 1'b1; b_rd = 5'd6; b_data = 64'h66;
      tick();
      iss_set = 1'b0; b_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0; a_valid = 1'b0;
      settle();
      chk("mr_rf_we",    rf_we,    1'b0);
      chk("mr_rs1_busy", rs1_busy, 1'b0);
      chk("mr_b_ready",  b_ready,  1'b1);
      tick();
      chk("mr_drained_we", rf_we, 1'b0);
      tick();
      chk("mr_drained_we2", rf_we, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
